// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
//   funct3 encodings, FSM state enum, store lane payload and steering function.
package lsu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NBYTES = XLEN / 8;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic [NBYTES-1:0] we;
      logic [XLEN-1:0]   wdata;
   } lsu_store_t;

   // Byte-enable and lane-replicated data for a store of the given width.
   function automatic lsu_store_t lsu_store_lanes(input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] wdata);
      lsu_store_t s;
      s.we    = '0;
      s.wdata = '0;
      case (funct3)
         F3_SB: begin
            s.we    = 4'b0001 << addr_lo;
            s.wdata = {4{wdata[7:0]}};
         end
         F3_SH: begin
            s.we    = 4'b0011 << {addr_lo[1], 1'b0};
            s.wdata = {2{wdata[15:0]}};
         end
         F3_SW: begin
            s.we    = 4'b1111;
            s.wdata = wdata;
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extraction: shift the read word down to the addressed byte lane
// and sign/zero extend according to funct3.
//   rdata_i   : raw word from data memory
//   addr_lo_i : byte offset within the word
//   funct3_i  : load width/sign
//   result_o  : extended 32-bit load result
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0] shifted;

   assign shifted = rdata_i >> {addr_lo_i, 3'b000};

   // LW is always aligned, so the shifted word equals the raw word.
   always_comb begin
      result_o = '0;
      case (funct3_i)
         F3_LB:   result_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  result_o = {24'd0, shifted[7:0]};
         F3_LH:   result_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_LHU:  result_o = {16'd0, shifted[15:0]};
         F3_LW:   result_o = shifted;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: launches one data-memory access per legal
// load/store, stalls the pipeline until it completes, and flags
// misaligned/illegal accesses without touching memory.
//   mem_valid/mem_read/mem_write/funct3/addr/wdata : MEM-stage instruction
//   stall (comb), lsu_fault (comb)                 : pipeline control
//   rdata/rdata_valid/bus_err                      : registered results
//   dm_req/dm_we/dm_addr/dm_wdata (reg), dm_gnt/dm_rvalid/dm_rdata : memory port
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_valid,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic [XLEN-1:0] rdata,
   output logic            rdata_valid,
   output logic            lsu_fault,
   output logic            bus_err,
   output logic            dm_req,
   output logic [3:0]      dm_we,
   output logic [XLEN-1:0] dm_addr,
   output logic [XLEN-1:0] dm_wdata,
   input  logic            dm_gnt,
   input  logic            dm_rvalid,
   input  logic [XLEN-1:0] dm_rdata
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_load_q, is_load_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic [2:0]       f3_q, f3_d;
   logic             dm_req_q, dm_req_d;
   logic [3:0]       dm_we_q, dm_we_d;
   logic [XLEN-1:0]  dm_addr_q, dm_addr_d;
   logic [XLEN-1:0]  dm_wdata_q, dm_wdata_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic             rdata_valid_q, rdata_valid_d;
   logic             bus_err_q, bus_err_d;

   logic             ld_fault, st_fault, access, fault, legal, to_hit;
   logic [XLEN-1:0]  ext_data;
   lsu_store_t       st_lanes;

   // Width/alignment legality of the incoming access.
   always_comb begin
      ld_fault = 1'b0;
      st_fault = 1'b0;
      case (funct3)
         F3_LB, F3_LBU: ld_fault = 1'b0;
         F3_LH, F3_LHU: ld_fault = addr[0];
         F3_LW:         ld_fault = |addr[1:0];
         default:       ld_fault = 1'b1;
      endcase
      case (funct3)
         F3_SB:   st_fault = 1'b0;
         F3_SH:   st_fault = addr[0];
         F3_SW:   st_fault = |addr[1:0];
         default: st_fault = 1'b1;
      endcase
   end

   assign access = mem_valid & (mem_read | mem_write);
   assign fault  = mem_valid & ((mem_read & mem_write) | (mem_read & ld_fault) |
                                (mem_write & st_fault));
   assign legal  = access & ~fault;

   assign st_lanes = lsu_store_lanes(funct3, addr[1:0], wdata);
   // Last counted cycle: completing now is still in time, otherwise abandon.
   assign to_hit   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   lsu_load_extend u_load_extend (
      .rdata_i   (dm_rdata),
      .addr_lo_i (addr_lo_q),
      .funct3_i  (f3_q),
      .result_o  (ext_data)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_load_d     = is_load_q;
      addr_lo_d     = addr_lo_q;
      f3_d          = f3_q;
      dm_req_d      = dm_req_q;
      dm_we_d       = dm_we_q;
      dm_addr_d     = dm_addr_q;
      dm_wdata_d    = dm_wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      bus_err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (legal) begin
               state_d    = REQ;
               cnt_d      = '0;
               is_load_d  = mem_read;
               addr_lo_d  = addr[1:0];
               f3_d       = funct3;
               dm_req_d   = 1'b1;
               dm_addr_d  = {addr[XLEN-1:2], 2'b00};
               dm_we_d    = mem_read ? 4'b0000 : st_lanes.we;
               dm_wdata_d = mem_read ? '0 : st_lanes.wdata;
            end
         end
         REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dm_gnt && !is_load_q) begin
               state_d  = DONE;
               dm_req_d = 1'b0;
            end else if (to_hit) begin
               state_d   = DONE;
               dm_req_d  = 1'b0;
               bus_err_d = 1'b1;
               rdata_d   = '0;
            end else if (dm_gnt) begin
               state_d  = WAIT_R;
               dm_req_d = 1'b0;
            end
         end
         WAIT_R: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dm_rvalid) begin
               state_d       = DONE;
               rdata_d       = ext_data;
               rdata_valid_d = 1'b1;
            end else if (to_hit) begin
               state_d   = DONE;
               bus_err_d = 1'b1;
               rdata_d   = '0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         is_load_q     <= 1'b0;
         addr_lo_q     <= '0;
         f3_q          <= '0;
         dm_req_q      <= 1'b0;
         dm_we_q       <= '0;
         dm_addr_q     <= '0;
         dm_wdata_q    <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_load_q     <= is_load_d;
         addr_lo_q     <= addr_lo_d;
         f3_q          <= f3_d;
         dm_req_q      <= dm_req_d;
         dm_we_q       <= dm_we_d;
         dm_addr_q     <= dm_addr_d;
         dm_wdata_q    <= dm_wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         bus_err_q     <= bus_err_d;
      end
   end

   assign stall       = (state_q == IDLE && legal) || state_q == REQ || state_q == WAIT_R;
   assign lsu_fault   = (state_q == IDLE) && fault;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign bus_err     = bus_err_q;
   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed table, hand-written reset
// sequences, and randomized accesses against a behavioural model.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        dm_gnt, dm_rvalid;
   logic [31:0] dm_rdata;
   logic        use_to;

   logic        stall_a, rdata_valid_a, lsu_fault_a, bus_err_a, dm_req_a;
   logic [31:0] rdata_a, dm_addr_a, dm_wdata_a;
   logic [3:0]  dm_we_a;
   logic        stall_b, rdata_valid_b, lsu_fault_b, bus_err_b, dm_req_b;
   logic [31:0] rdata_b, dm_addr_b, dm_wdata_b;
   logic [3:0]  dm_we_b;

   logic        mv_a, mv_b;
   logic        t_stall, t_rv, t_fault, t_berr, t_req;
   logic [31:0] t_rdata, t_addr, t_wdata;
   logic [3:0]  t_we;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign mv_a = mem_valid & ~use_to;
   assign mv_b = mem_valid & use_to;

   assign t_stall = use_to ? stall_b       : stall_a;
   assign t_rv    = use_to ? rdata_valid_b : rdata_valid_a;
   assign t_fault = use_to ? lsu_fault_b   : lsu_fault_a;
   assign t_berr  = use_to ? bus_err_b     : bus_err_a;
   assign t_req   = use_to ? dm_req_b      : dm_req_a;
   assign t_rdata = use_to ? rdata_b       : rdata_a;
   assign t_addr  = use_to ? dm_addr_b     : dm_addr_a;
   assign t_wdata = use_to ? dm_wdata_b    : dm_wdata_a;
   assign t_we    = use_to ? dm_we_b       : dm_we_a;

   lsu_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mv_a), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
      .stall(stall_a), .rdata(rdata_a), .rdata_valid(rdata_valid_a),
      .lsu_fault(lsu_fault_a), .bus_err(bus_err_a), .dm_req(dm_req_a),
      .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
   );

   lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .mem_valid(mv_b), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
      .stall(stall_b), .rdata(rdata_b), .rdata_valid(rdata_valid_b),
      .lsu_fault(lsu_fault_b), .bus_err(bus_err_b), .dm_req(dm_req_b),
      .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
   );

   typedef struct {
      int          stall, req, fault, rv, berr, both, extra;
      logic [31:0] rdata, daddr, dwdata;
      logic [3:0]  we;
      bit          seen, hung;
   } res_t;

   typedef struct {
      bit          fault, rv, berr, is_st, is_ld;
      int          stall, req;
      logic [31:0] rdata, daddr, wdata;
      logic [3:0]  we;
   } exp_t;

   typedef struct {
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, wd, rw;
      int          gl, rl;
      bit          e_fault;
      logic [3:0]  e_we;
      logic [31:0] e_wdata;
      int          e_stall;
      bit          e_rv;
      logic [31:0] e_rdata;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
      end
   endtask

   // Behavioural model: outcome of one access from the architectural rules.
   function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rw, input int gl, input int rl,
                                  input int to);
      exp_t e;
      int nb, lo, active;
      bit bad;
      logic [31:0] sh, mask;
      e = '{default: '0};
      if (!rd && !wr) return e;
      if (rd && wr) begin e.fault = 1; return e; end
      bad = rd ? (f3 == 3 || f3 >= 6) : (f3 > 2);
      nb  = 1 << (f3 % 4);
      lo  = a % 4;
      if (!bad && (lo % nb) != 0) bad = 1;
      if (bad) begin e.fault = 1; return e; end
      e.daddr = a - lo;
      active  = wr ? gl + 1 : gl + 1 + rl;
      e.req   = (gl + 1 < to) ? gl + 1 : to;
      if (active > to) begin
         e.berr = 1; e.stall = 1 + to; e.rdata = 0;
      end else begin
         e.stall = 1 + active; e.rv = rd;
      end
      if (wr) begin
         e.is_st = 1;
         for (int i = 0; i < 4; i++) begin
            e.we[i] = (i >= lo && i < lo + nb);
            e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
         end
      end else begin
         e.is_ld = 1;
         e.we = 0;
         if (!e.berr) begin
            sh   = rw >> (8 * lo);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
            e.rdata = sh & mask;
            if (f3 < 4 && nb < 4 && sh[8*nb-1]) e.rdata = e.rdata | ~mask;
         end
      end
      return e;
   endfunction

   // Apply one access with a responding memory; called at posedge+1, returns at posedge+1.
   task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int gl, input int rl,
                            output res_t r);
      int  req_n, gnt_cyc;
      bit  done;
      r = '{default: '0};
      r.hung = 1;
      req_n = 0; gnt_cyc = -1; done = 0;
      mem_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      for (int c = 0; c < 600; c++) begin
         dm_gnt = 0; dm_rvalid = 0; dm_rdata = $urandom;
         if (t_req) begin
            req_n++;
            if (req_n > gl) begin dm_gnt = 1; gnt_cyc = c; end
         end
         if (gnt_cyc >= 0 && c == gnt_cyc + rl) begin dm_rvalid = 1; dm_rdata = rw; end
         @(negedge clk);
         if (t_req) begin
            r.req++;
            if (!r.seen) begin r.seen = 1; r.we = t_we; r.daddr = t_addr; r.dwdata = t_wdata; end
         end
         r.stall += int'(t_stall);
         r.fault += int'(t_fault);
         r.rv    += int'(t_rv);
         r.berr  += int'(t_berr);
         if (t_stall && t_rv) r.both++;
         if (t_rv || t_berr) r.rdata = t_rdata;
         done = !t_stall;
         @(posedge clk); #1;
         if (done) begin r.hung = 0; break; end
      end
      mem_valid = 0; dm_gnt = 0; dm_rvalid = 0;
      @(negedge clk);
      r.extra = int'(t_rv | t_berr | t_req | t_stall);
      @(posedge clk); #1;
   endtask

   task automatic compare(input string tag, input res_t r, input exp_t e);
      chk($sformatf("%s hung", tag), 32'(r.hung), 32'd0);
      chk($sformatf("%s fault", tag), 32'(r.fault), 32'(e.fault));
      chk($sformatf("%s stall", tag), 32'(r.stall), 32'(e.stall));
      chk($sformatf("%s req", tag), 32'(r.req), 32'(e.req));
      chk($sformatf("%s rv", tag), 32'(r.rv), 32'(e.rv));
      chk($sformatf("%s berr", tag), 32'(r.berr), 32'(e.berr));
      chk($sformatf("%s stall_and_rv", tag), 32'(r.both), 32'd0);
      chk($sformatf("%s after", tag), 32'(r.extra), 32'd0);
      if (e.rv || e.berr) chk($sformatf("%s rdata", tag), r.rdata, e.rdata);
      if (e.req > 0) begin
         chk($sformatf("%s daddr", tag), r.daddr, e.daddr);
         chk($sformatf("%s we", tag), 32'(r.we), 32'(e.we));
         if (e.is_st) chk($sformatf("%s wdata", tag), r.dwdata, e.wdata);
      end
   endtask

   vec_t tbl[12];
   res_t r;
   exp_t e;
   int   rvc;

   initial begin
      tbl[0]  = '{0,1,3'd2,32'h100,32'hDEADBEEF,32'h0,0,1, 0,4'b1111,32'hDEADBEEF,2,0,32'h0};
      tbl[1]  = '{0,1,3'd0,32'h103,32'h000000A5,32'h0,0,1, 0,4'b1000,32'hA5A5A5A5,2,0,32'h0};
      tbl[2]  = '{1,0,3'd0,32'h102,32'h0,32'h0080FF00,0,1, 0,4'b0000,32'h0,3,1,32'hFFFFFF80};
      tbl[3]  = '{1,0,3'd4,32'h102,32'h0,32'h0080FF00,0,1, 0,4'b0000,32'h0,3,1,32'h00000080};
      tbl[4]  = '{1,0,3'd5,32'h102,32'h0,32'h0080FF00,0,1, 0,4'b0000,32'h0,3,1,32'h00000080};
      tbl[5]  = '{1,0,3'd2,32'h101,32'h0,32'h0,0,1,        1,4'b0000,32'h0,0,0,32'h0};
      tbl[6]  = '{1,1,3'd2,32'h100,32'h0,32'h0,0,1,        1,4'b0000,32'h0,0,0,32'h0};
      tbl[7]  = '{1,0,3'd2,32'h200,32'h0,32'h12345678,3,2, 0,4'b0000,32'h0,7,1,32'h12345678};
      tbl[8]  = '{0,1,3'd1,32'h102,32'h1234BEEF,32'h0,0,1, 0,4'b1100,32'hBEEFBEEF,2,0,32'h0};
      tbl[9]  = '{1,0,3'd1,32'h100,32'h0,32'h00008001,0,1, 0,4'b0000,32'h0,3,1,32'hFFFF8001};
      tbl[10] = '{1,0,3'd3,32'h100,32'h0,32'h0,0,1,        1,4'b0000,32'h0,0,0,32'h0};
      tbl[11] = '{0,1,3'd4,32'h100,32'h0,32'h0,0,1,        1,4'b0000,32'h0,0,0,32'h0};

      rst_n = 0; use_to = 0; mem_valid = 0; mem_read = 0; mem_write = 0;
      funct3 = 0; addr = 0; wdata = 0; dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
      repeat (2) @(negedge clk);
      chk("reset stall", 32'(stall_a), 32'd0);
      chk("reset dm_req", 32'(dm_req_a), 32'd0);
      chk("reset dm_we", 32'(dm_we_a), 32'd0);
      chk("reset dm_addr", dm_addr_a, 32'd0);
      chk("reset rdata", rdata_a, 32'd0);
      chk("reset pulses", 32'({rdata_valid_a, bus_err_a, lsu_fault_a}), 32'd0);
      rst_n = 1;
      @(posedge clk); #1;

      // Directed table.
      foreach (tbl[i]) begin
         do_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rw,
                   tbl[i].gl, tbl[i].rl, r);
         chk($sformatf("tbl%0d fault", i), 32'(r.fault), 32'(tbl[i].e_fault));
         chk($sformatf("tbl%0d stall", i), 32'(r.stall), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d rv", i), 32'(r.rv), 32'(tbl[i].e_rv));
         chk($sformatf("tbl%0d after", i), 32'(r.extra), 32'd0);
         if (tbl[i].e_rv) chk($sformatf("tbl%0d rdata", i), r.rdata, tbl[i].e_rdata);
         if (tbl[i].e_fault) chk($sformatf("tbl%0d req", i), 32'(r.req), 32'd0);
         else begin
            chk($sformatf("tbl%0d we", i), 32'(r.we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d daddr", i), r.daddr, {tbl[i].a[31:2], 2'b00});
            if (tbl[i].wr) chk($sformatf("tbl%0d wdata", i), r.dwdata, tbl[i].e_wdata);
         end
      end

      // Timeout on the short-timeout instance: no grant ever.
      use_to = 1;
      do_access(1, 0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 100, 1, r);
      chk("timeout stall", 32'(r.stall), 32'd5);
      chk("timeout berr", 32'(r.berr), 32'd1);
      chk("timeout rdata", r.rdata, 32'd0);
      chk("timeout rv", 32'(r.rv), 32'd0);
      chk("timeout req", 32'(r.req), 32'd4);
      use_to = 0;

      // Reset while in REQ: dm_req must drop without waiting for a clock.
      mem_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h400;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstreq dm_req before", 32'(dm_req_a), 32'd1);
      mem_valid = 0; rst_n = 0; #1;
      chk("rstreq dm_req after", 32'(dm_req_a), 32'd0);
      chk("rstreq stall after", 32'(stall_a), 32'd0);
      #1 rst_n = 1;
      @(posedge clk); #1;

      // Reset while in WAIT_R, followed by a stale dm_rvalid.
      mem_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h500;
      @(posedge clk); #1;
      dm_gnt = 1;
      @(posedge clk); #1;
      dm_gnt = 0;
      @(negedge clk);
      chk("rstwait stall before", 32'(stall_a), 32'd1);
      mem_valid = 0; rst_n = 0; #1;
      chk("rstwait stall after", 32'(stall_a), 32'd0);
      chk("rstwait dm_req after", 32'(dm_req_a), 32'd0);
      #1 rst_n = 1;
      @(posedge clk); #1;
      dm_rvalid = 1; dm_rdata = 32'h55AA55AA;
      rvc = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rvc += int'(rdata_valid_a | stall_a);
         @(posedge clk); #1;
         dm_rvalid = 0;
      end
      chk("rstwait stale rvalid", 32'(rvc), 32'd0);

      // Randomized accesses against the model.
      for (int n = 0; n < 300; n++) begin
         int k, gl, rl;
         bit rd, wr;
         logic [2:0] f3;
         logic [31:0] a, wd, rw;
         k  = $urandom_range(0, 9);
         rd = (k == 1) || (k >= 2 && k <= 5);
         wr = (k == 1) || (k >= 6);
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         wd = $urandom; rw = $urandom;
         gl = $urandom_range(0, 4);
         rl = $urandom_range(1, 3);
         use_to = ($urandom_range(0, 3) == 0);
         e = model(rd, wr, f3, a, wd, rw, gl, rl, use_to ? 4 : 255);
         do_access(rd, wr, f3, a, wd, rw, gl, rl, r);
         compare($sformatf("rnd%0d", n), r, e);
      end
      use_to = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
